// File: rtl/core_dma_rd_initiator.sv
// core_dma_rd_initiator: splits byte-granular DMA reads into 16-byte commands and streams returned beats
module core_dma_rd_initiator #(
    parameter int DATA_WIDTH      = 128,
    parameter int STRB_WIDTH      = DATA_WIDTH / 8,
    parameter int ADDR_WIDTH      = 26,
    parameter int LEN_WIDTH       = 16,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LEN_WIDTH-1:0]  req_len,
    input  logic                  req_valid,
    output logic                  req_ready,
    output logic                  dma_cmd_rd_en,
    output logic [ADDR_WIDTH-1:0] dma_cmd_rd_addr,
    output logic                  dma_cmd_rd_last,
    input  logic                  dma_cmd_rd_ready,
    input  logic                  dma_rd_resp_valid,
    input  logic [DATA_WIDTH-1:0] dma_rd_resp_data,
    output logic                  dma_rd_resp_ready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [STRB_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic                  busy,
    output logic                  err_zero_len,
    output logic                  err_stray_resp
);
    localparam int CW = LEN_WIDTH - 3;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

    state_t                r_state, w_next;
    logic [ADDR_WIDTH-1:0] r_cur_addr;
    logic [CW-1:0]         r_cmd_cnt, r_resp_cnt;
    logic [STRB_WIDTH-1:0] r_last_keep;
    logic [OW-1:0]         r_outstanding;
    logic                  r_err_zero, r_err_stray;

    logic [CW-1:0]         w_beats;
    logic [STRB_WIDTH-1:0] w_keep;
    logic                  w_req_hs, w_cmd_hs, w_resp_hs;

    // a partial final beat still costs a whole 16-byte command
    assign w_beats  = {1'b0, req_len[LEN_WIDTH-1:4]} + CW'(|req_len[3:0]);
    assign w_keep   = (req_len[3:0] == 4'd0) ? '1 : (STRB_WIDTH'(1) << req_len[3:0]) - STRB_WIDTH'(1);
    assign w_req_hs  = req_ready && req_valid;
    assign w_cmd_hs  = dma_cmd_rd_en && dma_cmd_rd_ready;
    assign w_resp_hs = (r_state != S_IDLE) && dma_rd_resp_valid && m_axis_tready;

    assign dma_cmd_rd_addr = r_cur_addr;
    assign m_axis_tdata    = dma_rd_resp_data;
    assign m_axis_tkeep    = m_axis_tlast ? r_last_keep : '1;
    assign busy            = r_state != S_IDLE;
    assign err_zero_len    = r_err_zero;
    assign err_stray_resp  = r_err_stray;

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // next state, command issue gating and response pass-through
    always_comb begin
        w_next            = r_state;
        req_ready         = 1'b0;
        dma_cmd_rd_en     = 1'b0;
        dma_cmd_rd_last   = 1'b0;
        dma_rd_resp_ready = 1'b1;
        m_axis_tvalid     = 1'b0;
        m_axis_tlast      = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid && req_len != '0) w_next = S_ISSUE;
            end
            S_ISSUE: begin
                dma_cmd_rd_en   = r_outstanding < OW'(MAX_OUTSTANDING);
                dma_cmd_rd_last = r_cmd_cnt == CW'(1);
                if (dma_cmd_rd_en && dma_cmd_rd_ready && dma_cmd_rd_last) w_next = S_DRAIN;
            end
            default: ;
        endcase
        if (r_state != S_IDLE) begin
            dma_rd_resp_ready = m_axis_tready;
            m_axis_tvalid     = dma_rd_resp_valid;
            m_axis_tlast      = r_resp_cnt == CW'(1);
            if (dma_rd_resp_valid && m_axis_tready && m_axis_tlast) w_next = S_IDLE;
        end
    end

    // request latch, address/beat counters, outstanding tracking and error pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cur_addr    <= '0;
            r_cmd_cnt     <= '0;
            r_resp_cnt    <= '0;
            r_last_keep   <= '0;
            r_outstanding <= '0;
            r_err_zero    <= 1'b0;
            r_err_stray   <= 1'b0;
        end else begin
            r_err_zero  <= w_req_hs && (req_len == '0);
            r_err_stray <= (r_state == S_IDLE) && dma_rd_resp_valid;
            if (w_req_hs && req_len != '0) begin
                r_cur_addr  <= req_addr & ~ADDR_WIDTH'(15);
                r_cmd_cnt   <= w_beats;
                r_resp_cnt  <= w_beats;
                r_last_keep <= w_keep;
            end else begin
                if (w_cmd_hs) begin
                    r_cur_addr <= r_cur_addr + ADDR_WIDTH'(16);
                    r_cmd_cnt  <= r_cmd_cnt - CW'(1);
                end
                if (w_resp_hs) r_resp_cnt <= r_resp_cnt - CW'(1);
            end
            if (w_cmd_hs && !w_resp_hs)
                r_outstanding <= r_outstanding + OW'(1);
            else if (!w_cmd_hs && w_resp_hs && r_outstanding != '0)
                r_outstanding <= r_outstanding - OW'(1);
        end
    end
endmodule
